// File: rtl/router_input_unit_pkg.sv
// Shared flit field layout, flit type codes, output-port codes and FSM states
// for the router input unit.
package router_input_unit_pkg;

  localparam int TYPE_W   = 2;
  localparam int PORT_W   = 4;
  localparam int SRC_LSB  = 4;
  localparam int DEST_LSB = 0;

  typedef enum logic [1:0] {
    FLIT_TYPE_SINGLE = 2'b00,
    FLIT_TYPE_HEAD   = 2'b01,
    FLIT_TYPE_BODY   = 2'b10,
    FLIT_TYPE_TAIL   = 2'b11
  } flit_type_t;

  localparam logic [PORT_W-1:0] PORT_LOCAL = 4'b0000;
  localparam logic [PORT_W-1:0] PORT_S     = 4'b0001;
  localparam logic [PORT_W-1:0] PORT_W_    = 4'b0010;
  localparam logic [PORT_W-1:0] PORT_E     = 4'b0100;
  localparam logic [PORT_W-1:0] PORT_N     = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUTE,
    ST_REQ,
    ST_XFER
  } state_t;

  function automatic logic is_head(input flit_type_t t);
    return (t == FLIT_TYPE_SINGLE) || (t == FLIT_TYPE_HEAD);
  endfunction

  function automatic logic is_last(input flit_type_t t);
    return (t == FLIT_TYPE_SINGLE) || (t == FLIT_TYPE_TAIL);
  endfunction

endpackage

// File: rtl/router_input_unit_if.sv
// Link, route-block and allocator signals of one router input port.
// master = upstream/environment side, slave = the input unit.
interface router_input_unit_if #(
  parameter int FLIT_W = 16,
  parameter int ADDR_W = 4
);
  logic [FLIT_W-1:0] in_flit;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] my_addr;
  logic [ADDR_W-1:0] dest_addr;
  logic [3:0]        route_port;
  logic [3:0]        req_port;
  logic              req_valid;
  logic              grant;
  logic [FLIT_W-1:0] out_flit;
  logic              out_valid;
  logic              out_ready;
  logic              pkt_release;
  logic              proto_err;

  modport master (
    output in_flit, in_valid, my_addr, route_port, grant, out_ready,
    input  in_ready, src_addr, dest_addr, req_port, req_valid,
           out_flit, out_valid, pkt_release, proto_err
  );

  modport slave (
    input  in_flit, in_valid, my_addr, route_port, grant, out_ready,
    output in_ready, src_addr, dest_addr, req_port, req_valid,
           out_flit, out_valid, pkt_release, proto_err
  );
endinterface

// File: rtl/router_input_unit_flit_fifo.sv
// DEPTH x W flit buffer; read data is the head combinationally, push/pop take effect next edge.
// Caller must not push when full or pop when empty.
module flit_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdat,
  input  logic         pop,
  output logic [W-1:0] rdat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign rdat  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wdat;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/router_input_unit.sv
// Router input port: buffers flits, routes the head, requests the allocator, streams head..tail.
// Head reaches out_valid 3 cycles after reaching the FIFO front; in_ready=!full, waits on grant/out_ready.
module router_input_unit
  import router_input_unit_pkg::*;
#(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4
) (
  input logic                clk,
  input logic                rst_n,
  router_input_unit_if.slave bus
);
  logic [FLIT_W-1:0] head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  flit_type_t        head_type;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] dest_q;
  logic [3:0]        req_port_q;
  logic              req_valid_q;

  logic              load_dest;
  logic              load_req;
  logic              clr_req;
  logic              drop;
  logic              out_vld;
  logic              rel;

  flit_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdat  (bus.in_flit),
    .pop   (pop),
    .rdat  (head),
    .full  (full),
    .empty (empty)
  );

  assign head_type = flit_type_t'(head[FLIT_W-1 -: TYPE_W]);

  // Held low while reset is asserted so nothing is accepted into a clearing FIFO.
  assign bus.in_ready = rst_n & ~full;
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = drop | (out_vld & bus.out_ready);

  always_comb begin
    state_nxt = state;
    load_dest = 1'b0;
    load_req  = 1'b0;
    clr_req   = 1'b0;
    drop      = 1'b0;
    out_vld   = 1'b0;
    rel       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          if (is_head(head_type)) begin
            load_dest = 1'b1;
            state_nxt = ST_ROUTE;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_ROUTE: begin
        load_req  = 1'b1;
        state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (bus.grant) state_nxt = ST_XFER;
      end
      ST_XFER: begin
        out_vld = ~empty & bus.grant;
        if (out_vld && bus.out_ready && is_last(head_type)) begin
          rel       = 1'b1;
          clr_req   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      dest_q      <= '0;
      req_port_q  <= '0;
      req_valid_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_dest) dest_q <= head[DEST_LSB +: ADDR_W];
      if (load_req) begin
        req_port_q  <= bus.route_port;
        req_valid_q <= 1'b1;
      end else if (clr_req) begin
        req_valid_q <= 1'b0;
      end
    end
  end

  assign bus.src_addr    = bus.my_addr;
  assign bus.dest_addr   = dest_q;
  assign bus.req_port    = req_port_q;
  assign bus.req_valid   = req_valid_q;
  assign bus.out_valid   = out_vld;
  assign bus.out_flit    = (state == ST_XFER) ? head : '0;
  assign bus.pkt_release = rel;
  assign bus.proto_err   = drop;
endmodule

// File: tb/tb_router_input_unit.sv
// Directed bench for router_input_unit: scoreboard of accepted flits vs. crossbar output,
// with an XY route-block stand-in and a scripted allocator grant.
module tb_router_input_unit;
  import router_input_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  router_input_unit_if bus ();

  router_input_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [3:0] xy_route(input logic [3:0] me, input logic [3:0] dst);
    if (dst[1:0] > me[1:0]) return PORT_E;
    if (dst[1:0] < me[1:0]) return PORT_W_;
    if (dst[3:2] > me[3:2]) return PORT_N;
    if (dst[3:2] < me[3:2]) return PORT_S;
    return PORT_LOCAL;
  endfunction

  assign bus.route_port = xy_route(bus.my_addr, bus.dest_addr);

  function automatic logic [15:0] mk(input logic [1:0] t, input logic [5:0] pl, input logic [3:0] dst);
    return {t, pl, 4'h5, dst};
  endfunction

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] src_q [$];
  logic [15:0] exp_q [$];
  int   outs, rels, perrs, cyc_no, first_out_cyc, head_acc_cyc, n;
  bit   auto_grant;
  logic s_out_valid, s_req_valid, s_in_ready;
  logic [3:0] s_req_port, s_dest;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    bus.in_valid = (src_q.size() > 0);
    bus.in_flit  = (src_q.size() > 0) ? src_q[0] : 16'h0;
  endtask

  // One clock: sample/score at negedge, then drive the next inputs just after posedge.
  task automatic cyc();
    logic [15:0] e;
    @(negedge clk);
    cyc_no++;
    s_out_valid = bus.out_valid;
    s_req_valid = bus.req_valid;
    s_in_ready  = bus.in_ready;
    if (bus.req_valid) begin
      s_req_port = bus.req_port;
      s_dest     = bus.dest_addr;
    end
    if (bus.out_valid && bus.out_ready) begin
      check("sb_flit_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_flit", 32'(bus.out_flit), 32'(e));
      end
      if (outs == 0) first_out_cyc = cyc_no;
      outs++;
    end
    if (bus.pkt_release) begin
      rels++;
      check("release_on_last_pop",
            32'({bus.out_valid & bus.out_ready, is_last(flit_type_t'(bus.out_flit[15:14]))}), 32'd3);
    end
    if (bus.proto_err) begin
      perrs++;
      if (exp_q.size() > 0) e = exp_q.pop_front();
    end
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(bus.in_flit);
      if (is_head(flit_type_t'(bus.in_flit[15:14]))) head_acc_cyc = cyc_no;
      e = src_q.pop_front();
    end
    @(posedge clk);
    #1;
    drive_src();
    if (auto_grant) bus.grant = bus.req_valid;
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int k = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && k < budget) begin
      cyc();
      k++;
    end
    check({tag, "_timeout"}, 32'(k < budget), 32'd1);
    repeat (3) cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_q.delete();
    exp_q.delete();
    drive_src();
    bus.grant = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clr_counts();
    outs = 0; rels = 0; perrs = 0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_flit   = '0;
    bus.in_valid  = 1'b0;
    bus.my_addr   = 4'b0101;
    bus.grant     = 1'b0;
    bus.out_ready = 1'b1;
    auto_grant    = 1'b1;
    cyc_no = 0; head_acc_cyc = 0; first_out_cyc = 0;
    s_req_port = '0; s_dest = '0;
    clr_counts();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_flit",  32'(bus.out_flit), 32'd0);
    check("rst_req_valid", 32'(bus.req_valid), 32'd0);
    check("rst_req_port",  32'(bus.req_port), 32'd0);
    check("rst_dest_addr", 32'(bus.dest_addr), 32'd0);
    check("rst_release",   32'(bus.pkt_release), 32'd0);
    check("rst_proto_err", 32'(bus.proto_err), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("src_addr_copy", 32'(bus.src_addr), 32'h5);

    // Body flit first after reset: dropped with a proto_err pulse
    src_q.push_back(mk(2'b10, 6'h11, 4'h7));
    drive_src();
    repeat (8) cyc();
    check("perr_count", 32'(perrs), 32'd1);
    check("perr_no_out", 32'(outs), 32'd0);
    check("perr_no_req", 32'(s_req_valid), 32'd0);
    check("perr_dropped", 32'(exp_q.size()), 32'd0);

    // Head/body/tail to the east
    do_reset();
    clr_counts();
    src_q.push_back(mk(2'b01, 6'h01, 4'b0111));
    src_q.push_back(mk(2'b10, 6'h02, 4'h0));
    src_q.push_back(mk(2'b11, 6'h03, 4'h0));
    drive_src();
    run_until_idle(40, "t1");
    check("t1_dest_addr", 32'(s_dest), 32'b0111);
    check("t1_req_port", 32'(s_req_port), 32'(PORT_E));
    check("t1_outs", 32'(outs), 32'd3);
    check("t1_release", 32'(rels), 32'd1);
    check("t1_latency", 32'(first_out_cyc - head_acc_cyc), 32'd4);
    check("t1_req_dropped", 32'(s_req_valid), 32'd0);

    // Single flit for this node: local eject
    clr_counts();
    src_q.push_back(mk(2'b00, 6'h2a, 4'b0101));
    drive_src();
    run_until_idle(40, "t2");
    check("t2_req_port", 32'(s_req_port), 32'(PORT_LOCAL));
    check("t2_dest_addr", 32'(s_dest), 32'b0101);
    check("t2_outs", 32'(outs), 32'd1);
    check("t2_release", 32'(rels), 32'd1);

    // Five flits with downstream stalled: FIFO fills, fifth held upstream
    clr_counts();
    bus.out_ready = 1'b0;
    src_q.push_back(mk(2'b01, 6'h10, 4'b1101));
    for (int i = 0; i < 3; i++) src_q.push_back(mk(2'b10, 6'(8'h11 + i), 4'h0));
    src_q.push_back(mk(2'b11, 6'h14, 4'h0));
    drive_src();
    repeat (10) cyc();
    check("t3_in_ready_full", 32'(s_in_ready), 32'd0);
    check("t3_held_upstream", 32'(src_q.size()), 32'd1);
    check("t3_buffered", 32'(exp_q.size()), 32'd4);
    check("t3_no_out", 32'(outs), 32'd0);
    check("t3_req_port", 32'(s_req_port), 32'(PORT_N));
    bus.out_ready = 1'b1;
    run_until_idle(40, "t3");
    check("t3_outs", 32'(outs), 32'd5);
    check("t3_release", 32'(rels), 32'd1);

    // Grant delayed 10 cycles, then withdrawn for 2 cycles mid-packet
    clr_counts();
    auto_grant = 1'b0;
    bus.grant  = 1'b0;
    src_q.push_back(mk(2'b01, 6'h20, 4'b0100));
    src_q.push_back(mk(2'b10, 6'h21, 4'h0));
    src_q.push_back(mk(2'b10, 6'h22, 4'h0));
    src_q.push_back(mk(2'b11, 6'h23, 4'h0));
    drive_src();
    n = 0;
    while (!s_req_valid && n < 20) begin cyc(); n++; end
    check("t5_req_seen", 32'(n < 20), 32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (s_req_valid && !s_out_valid) n++;
    end
    check("t5_wait_req_held", 32'(n), 32'd10);
    check("t5_req_port", 32'(s_req_port), 32'(PORT_W_));
    bus.grant = 1'b1;
    n = 0;
    while (outs < 1 && n < 20) begin cyc(); n++; end
    check("t5_first_out", 32'(outs), 32'd1);
    bus.grant = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("t5_nogrant_out_valid", 32'(s_out_valid), 32'd0);
      check("t5_nogrant_req_valid", 32'(s_req_valid), 32'd1);
    end
    check("t5_outs_frozen", 32'(outs), 32'd1);
    bus.grant  = 1'b1;
    auto_grant = 1'b1;
    run_until_idle(40, "t5");
    check("t5_outs", 32'(outs), 32'd4);
    check("t5_release", 32'(rels), 32'd1);

    // Reset while the second of four flits is at the FIFO front
    clr_counts();
    src_q.push_back(mk(2'b01, 6'h30, 4'b0111));
    src_q.push_back(mk(2'b10, 6'h31, 4'h0));
    src_q.push_back(mk(2'b10, 6'h32, 4'h0));
    src_q.push_back(mk(2'b11, 6'h33, 4'h0));
    drive_src();
    n = 0;
    while (outs < 1 && n < 20) begin cyc(); n++; end
    check("t6_first_out", 32'(outs), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_out_flit",  32'(bus.out_flit), 32'd0);
    check("t6_rst_req_valid", 32'(bus.req_valid), 32'd0);
    check("t6_rst_req_port",  32'(bus.req_port), 32'd0);
    check("t6_rst_dest_addr", 32'(bus.dest_addr), 32'd0);
    check("t6_rst_in_ready",  32'(bus.in_ready), 32'd0);
    check("t6_rst_release",   32'(bus.pkt_release), 32'd0);
    src_q.delete();
    exp_q.delete();
    drive_src();
    bus.grant = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_counts();
    repeat (8) cyc();
    check("t6_fifo_empty_no_out", 32'(outs), 32'd0);
    check("t6_fifo_empty_no_perr", 32'(perrs), 32'd0);
    check("t6_no_release", 32'(rels), 32'd0);
    check("t6_idle_req_valid", 32'(s_req_valid), 32'd0);
    check("t6_in_ready", 32'(s_in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
